// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_sync_fifo
//  Description : Parameterised single-clock FIFO with registered status flags,
//                sticky overflow/underflow errors and a selectable read mode
//                (registered read or first-word-fall-through).
//  Ports       : clk, reset (async, active-high)
//                wr_en/din -> full, almost_full, overflow
//                rd_en     -> dout, rd_valid, empty, almost_empty, underflow
//                count (fill level), clr_err (clears sticky errors)
//  Revision    : 1.0  initial release
// ============================================================================
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic                        full,
    output logic                        almost_full,
    output logic                        overflow,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        rd_valid,
    output logic                        empty,
    output logic                        almost_empty,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] count,
    input  logic                        clr_err
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_AF    = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE    = c_CW'(AE_LEVEL);
    localparam logic [c_AW-1:0] c_PTR1  = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT1  = c_CW'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    generate
        if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
            (AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > FIFO_DEPTH)) begin : g_param_check
            $error("param_sync_fifo: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_ack;
    logic                  w_wr_ack;
    logic [c_CW-1:0]       w_count_d;

    // A write at full is still accepted when a read frees a slot in the same
    // cycle. There is deliberately no bypass: an empty FIFO never acks a read.
    assign w_rd_ack = rd_en && !r_empty;
    assign w_wr_ack = wr_en && (!r_full || w_rd_ack);

    always_comb begin
        w_count_d = r_count;
        case ({w_wr_ack, w_rd_ack})
            2'b10:   w_count_d = r_count + c_CNT1;
            2'b01:   w_count_d = r_count - c_CNT1;
            default: w_count_d = r_count;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ack) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, count and status flags. Flags are derived from the next count
    // so they are always consistent with the registered count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_ack) begin
                r_wr_ptr <= r_wr_ptr + c_PTR1;
            end
            if (w_rd_ack) begin
                r_rd_ptr <= r_rd_ptr + c_PTR1;
            end
            r_count        <= w_count_d;
            r_full         <= (w_count_d == c_DEPTH);
            r_empty        <= (w_count_d == '0);
            r_almost_full  <= (w_count_d >= c_AF);
            r_almost_empty <= (w_count_d <= c_AE);
        end
    end

    // Sticky error flags: a new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_ack) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; rd_en only acknowledges it.
            assign dout     = r_mem[r_rd_ptr];
            assign rd_valid = !r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_rd_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_dout     <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_ack;
                    if (w_rd_ack) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign dout     = r_dout;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_sync_fifo
//  Description : Self-checking bench for param_sync_fifo. A queue-based model
//                predicts every observable output; directed scenarios are
//                followed by a randomised traffic phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_sync_fifo;

    localparam int c_DW    = 8;
    localparam int c_DEPTH = 16;
    localparam int c_AF    = 12;
    localparam int c_AE    = 2;

    logic            clk;
    logic            reset;

    // Standard-read instance
    logic            wr_en, rd_en, clr_err;
    logic [c_DW-1:0] din, dout;
    logic            full, almost_full, overflow;
    logic            rd_valid, empty, almost_empty, underflow;
    logic [4:0]      count;

    // FWFT instance
    logic            f_wr_en, f_rd_en, f_clr_err;
    logic [c_DW-1:0] f_din, f_dout;
    logic            f_full, f_almost_full, f_overflow;
    logic            f_rd_valid, f_empty, f_almost_empty, f_underflow;
    logic [4:0]      f_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [c_DW-1:0] q[$];
    logic [c_DW-1:0] fq[$];
    logic            m_ovf, m_udf, m_valid;
    logic [c_DW-1:0] m_dout;

    param_sync_fifo #(
        .DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH), .AF_LEVEL(c_AF),
        .AE_LEVEL(c_AE), .FWFT(0)
    ) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
        .overflow(overflow), .rd_en(rd_en), .dout(dout), .rd_valid(rd_valid),
        .empty(empty), .almost_empty(almost_empty), .underflow(underflow),
        .count(count), .clr_err(clr_err)
    );

    param_sync_fifo #(
        .DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH), .AF_LEVEL(c_AF),
        .AE_LEVEL(c_AE), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset(reset),
        .wr_en(f_wr_en), .din(f_din), .full(f_full), .almost_full(f_almost_full),
        .overflow(f_overflow), .rd_en(f_rd_en), .dout(f_dout), .rd_valid(f_rd_valid),
        .empty(f_empty), .almost_empty(f_almost_empty), .underflow(f_underflow),
        .count(f_count), .clr_err(f_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        fq.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = '0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},        32'(count),        32'(n));
        chk({tag, ".full"},         32'(full),         32'(n == c_DEPTH));
        chk({tag, ".empty"},        32'(empty),        32'(n == 0));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= c_AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= c_AE));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_udf));
        chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_valid));
        chk({tag, ".dout"},         32'(dout),         32'(m_dout));
    endtask

    // One clock of traffic on the standard-read instance, then check.
    task automatic cyc(input string tag, input bit wr, input logic [c_DW-1:0] d,
                       input bit rd, input bit clr);
        int n;
        bit rack, wack;
        wr_en = wr; din = d; rd_en = rd; clr_err = clr;
        n    = q.size();
        rack = rd && (n != 0);
        wack = wr && ((n < c_DEPTH) || rack);
        if (wr && !wack) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (rd && n == 0) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
        m_valid = rack;
        if (rack) m_dout = q.pop_front();
        if (wack) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [c_DW-1:0] rd_data;
        wr_en = 0; rd_en = 0; clr_err = 0; din = '0;
        f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_din = '0;
        reset = 1'b1;
        model_reset();
        #1;
        // ---- Reset state (asynchronous: no edge has occurred yet) ----
        check_all("reset");
        chk("reset.fwft_rd_valid", 32'(f_rd_valid), 32'd0);
        chk("reset.fwft_empty",    32'(f_empty),    32'd1);
        #10;
        @(posedge clk); #1;
        reset = 1'b0;

        // ---- Single word ----
        cyc("single.wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        cyc("single.rd", 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("single.idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // ---- Fill to full, then overflow ----
        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  cyc("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
        cyc("ovf.clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // ---- Drain 16 plus one extra read: underflow ----
        for (int i = 0; i < 17; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("udf.clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // ---- Simultaneous read/write at full across pointer wrap ----
        for (int i = 0; i < 16; i++) cyc("sim.fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  cyc("sim.rw", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc("sim.drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // ---- FWFT instance ----
        chk("fwft.pre_empty", 32'(f_empty), 32'd1);
        f_wr_en = 1'b1; f_din = 8'h10;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft.empty",    32'(f_empty),    32'd0);
        chk("fwft.rd_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft.dout",     32'(f_dout),     32'h10);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        chk("fwft.pop_empty",    32'(f_empty),    32'd1);
        chk("fwft.pop_rd_valid", 32'(f_rd_valid), 32'd0);
        // Three words, head must track pops.
        for (int i = 0; i < 3; i++) begin
            f_wr_en = 1'b1; f_din = 8'(8'h20 + i); fq.push_back(f_din);
            @(posedge clk); #1;
        end
        f_wr_en = 1'b0;
        while (fq.size() != 0) begin
            rd_data = fq.pop_front();
            chk("fwft.head", 32'(f_dout), 32'(rd_data));
            chk("fwft.valid", 32'(f_rd_valid), 32'd1);
            f_rd_en = 1'b1;
            @(posedge clk); #1;
            f_rd_en = 1'b0;
        end
        chk("fwft.final_empty", 32'(f_empty), 32'd1);

        // ---- Randomised traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 70 : 30;
            cyc("rand",
                ($urandom_range(0, 99) < wp),
                8'($urandom),
                ($urandom_range(0, 99) < (100 - wp)),
                ($urandom_range(0, 19) == 0));
        end

        // ---- Mid-operation reset ----
        for (int i = 0; i < 5; i++) cyc("mid.wr", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid.count_async", 32'(count), 32'd0);
        chk("mid.empty_async", 32'(empty), 32'd1);
        check_all("mid.reset");
        @(posedge clk); #1;
        reset = 1'b0;
        cyc("mid.wr3c", 1'b1, 8'h3C, 1'b0, 1'b0);
        cyc("mid.rd3c", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid.first_read", 32'(dout), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
